addsub_arbiter: RTL and testbench

Two-requester scheduler that time-shares one registered signed add/subtract unit between a sum channel and a difference channel, e.g. L+R and L−R in stereo reconstruction. It reads operand pairs from two pairs of input FIFOs, arbitrates round-robin, computes x+y for requester 0 and x−y for requester 1, and writes each result to that requester's own output FIFO. It sits between the demodulator FIFOs and the per-channel audio output FIFOs.

---
 rtl/addsub_arbiter.sv | 154 +++++++++++++++
 tb/tb_addsub_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Round-robin scheduler sharing one registered signed add/subtract unit between a
// sum requester (0) and a difference requester (1). Define ADDSUB_SAT_EN to saturate results.
module addsub_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  x0_in,
    input  logic [DATA_WIDTH-1:0]  y0_in,
    input  logic                   x0_empty,
    input  logic                   y0_empty,
    output logic                   x0_rd_en,
    output logic                   y0_rd_en,
    input  logic [DATA_WIDTH-1:0]  x1_in,
    input  logic [DATA_WIDTH-1:0]  y1_in,
    input  logic                   x1_empty,
    input  logic                   y1_empty,
    output logic                   x1_rd_en,
    output logic                   y1_rd_en,
    input  logic                   out0_full,
    input  logic                   out1_full,
    output logic                   out0_wr_en,
    output logic                   out1_wr_en,
    output logic [DATA_WIDTH-1:0]  out0_dout,
    output logic [DATA_WIDTH-1:0]  out1_dout,
    output logic                   grant,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] count0,
    output logic [COUNT_WIDTH-1:0] count1
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_grant;
    logic                    r_last;
    logic [DATA_WIDTH-1:0]   r_x;
    logic [DATA_WIDTH-1:0]   r_y;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [COUNT_WIDTH-1:0]  r_count0;
    logic [COUNT_WIDTH-1:0]  r_count1;

    logic                    w_elig0;
    logic                    w_elig1;
    logic                    w_pick;
    logic                    w_rd0;
    logic                    w_rd1;
    logic                    w_write;
    logic                    w_out_full;
    logic [DATA_WIDTH:0]     w_wide;
    logic [DATA_WIDTH-1:0]   w_result;

    assign w_elig0    = !x0_empty && !y0_empty && !out0_full;
    assign w_elig1    = !x1_empty && !y1_empty && !out1_full;
    assign w_out_full = r_grant ? out1_full : out0_full;

    // One guard bit above the operands so overflow is visible as bit DW != bit DW-1.
    always_comb begin
        if (r_grant)
            w_wide = {r_x[DATA_WIDTH-1], r_x} - {r_y[DATA_WIDTH-1], r_y};
        else
            w_wide = {r_x[DATA_WIDTH-1], r_x} + {r_y[DATA_WIDTH-1], r_y};
    end

`ifdef ADDSUB_SAT_EN
    always_comb begin
        if (w_wide[DATA_WIDTH] != w_wide[DATA_WIDTH-1])
            w_result = {w_wide[DATA_WIDTH], {(DATA_WIDTH-1){~w_wide[DATA_WIDTH]}}};
        else
            w_result = w_wide[DATA_WIDTH-1:0];
    end
`else
    assign w_result = w_wide[DATA_WIDTH-1:0];
`endif

    always_comb begin
        w_next_state = r_state;
        w_pick       = r_grant;
        w_rd0        = 1'b0;
        w_rd1        = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_pick       = (w_elig0 && w_elig1) ? ~r_last : w_elig1;
                    w_rd0        = ~w_pick;
                    w_rd1        = w_pick;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD:  w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_WRITE;
            S_WRITE: begin
                if (!w_out_full) begin
                    w_write      = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
            r_count0 <= '0;
            r_count1 <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_rd0 || w_rd1)
                r_grant <= w_pick;
            if (r_state == S_LOAD) begin
                r_x <= r_grant ? x1_in : x0_in;
                r_y <= r_grant ? y1_in : y0_in;
            end
            if (r_state == S_EXEC)
                r_result <= w_result;
            if (w_write) begin
                r_last <= r_grant;
                if (r_grant)
                    r_count1 <= r_count1 + COUNT_WIDTH'(1);
                else
                    r_count0 <= r_count0 + COUNT_WIDTH'(1);
            end
        end
    end

    // IDLE is also the reset state, so pops are masked while reset is held.
    assign x0_rd_en   = w_rd0 && !reset;
    assign y0_rd_en   = w_rd0 && !reset;
    assign x1_rd_en   = w_rd1 && !reset;
    assign y1_rd_en   = w_rd1 && !reset;
    assign out0_wr_en = w_write && !r_grant;
    assign out1_wr_en = w_write && r_grant;
    assign out0_dout  = out0_wr_en ? r_result : '0;
    assign out1_dout  = out1_wr_en ? r_result : '0;
    assign grant      = r_grant;
    assign busy       = (r_state != S_IDLE);
    assign count0     = r_count0;
    assign count1     = r_count1;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter at DATA_WIDTH=8 with queue-backed FIFO models.
module tb_addsub_arbiter;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] x0_in = '0, y0_in = '0, x1_in = '0, y1_in = '0;
    logic          x0_empty = 1'b1, y0_empty = 1'b1, x1_empty = 1'b1, y1_empty = 1'b1;
    logic          x0_rd_en, y0_rd_en, x1_rd_en, y1_rd_en;
    logic          out0_full = 1'b0, out1_full = 1'b0;
    logic          out0_wr_en, out1_wr_en;
    logic [DW-1:0] out0_dout, out1_dout;
    logic          grant, busy;
    logic [CW-1:0] count0, count1;

    addsub_arbiter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .x0_in(x0_in), .y0_in(y0_in), .x0_empty(x0_empty), .y0_empty(y0_empty),
        .x0_rd_en(x0_rd_en), .y0_rd_en(y0_rd_en),
        .x1_in(x1_in), .y1_in(y1_in), .x1_empty(x1_empty), .y1_empty(y1_empty),
        .x1_rd_en(x1_rd_en), .y1_rd_en(y1_rd_en),
        .out0_full(out0_full), .out1_full(out1_full),
        .out0_wr_en(out0_wr_en), .out1_wr_en(out1_wr_en),
        .out0_dout(out0_dout), .out1_dout(out1_dout),
        .grant(grant), .busy(busy), .count0(count0), .count1(count1)
    );

    always #5 clock = ~clock;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_viol = 0;
    logic [DW-1:0] q0x[$], q0y[$], q1x[$], q1y[$];
    int            rd_req[$], rd_cyc[$], wr_req[$], wr_cyc[$];
    logic [DW-1:0] wr_dat[$];

    always @(posedge clock) cyc++;

    // Standard-read FIFO models: data appears the cycle after the pop.
    always @(posedge clock) begin
        if (x0_rd_en && q0x.size() > 0) begin
            x0_in <= q0x.pop_front();
            y0_in <= q0y.pop_front();
            x0_empty <= (q0x.size() == 0);
            y0_empty <= (q0y.size() == 0);
        end
        if (x1_rd_en && q1x.size() > 0) begin
            x1_in <= q1x.pop_front();
            y1_in <= q1y.pop_front();
            x1_empty <= (q1x.size() == 0);
            y1_empty <= (q1y.size() == 0);
        end
    end

    always @(negedge clock) begin
        if (x0_rd_en) begin rd_req.push_back(0); rd_cyc.push_back(cyc); end
        if (x1_rd_en) begin rd_req.push_back(1); rd_cyc.push_back(cyc); end
        if (out0_wr_en) begin wr_req.push_back(0); wr_cyc.push_back(cyc); wr_dat.push_back(out0_dout); end
        if (out1_wr_en) begin wr_req.push_back(1); wr_cyc.push_back(cyc); wr_dat.push_back(out1_dout); end
        if (x0_rd_en !== y0_rd_en || x1_rd_en !== y1_rd_en ||
            (x0_rd_en && x1_rd_en) || (out0_wr_en && out1_wr_en) ||
            (!out0_wr_en && out0_dout !== '0) || (!out1_wr_en && out1_dout !== '0))
            n_viol++;
    end

    task automatic clear_logs();
        rd_req.delete(); rd_cyc.delete(); wr_req.delete(); wr_cyc.delete(); wr_dat.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0x.delete(); q0y.delete(); q1x.delete(); q1y.delete();
        x0_empty = 1'b1; y0_empty = 1'b1; x1_empty = 1'b1; y1_empty = 1'b1;
        out0_full = 1'b0; out1_full = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clear_logs();
        reset = 1'b0;
    endtask

    task automatic push0(input logic [DW-1:0] x, input logic [DW-1:0] y);
        q0x.push_back(x); q0y.push_back(y);
        x0_empty = 1'b0; y0_empty = 1'b0;
    endtask

    task automatic push1(input logic [DW-1:0] x, input logic [DW-1:0] y);
        q1x.push_back(x); q1y.push_back(y);
        x1_empty = 1'b0; y1_empty = 1'b0;
    endtask

    task automatic wait_wr(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock); #1;
            if (wr_req.size() >= n) begin ok = 1'b1; break; end
        end
        repeat (8) @(posedge clock);
        #1;
    endtask

    task automatic wait_rd(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock); #1;
            if (rd_req.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b1;
        @(posedge clock); #1;
        push0(8'd1, 8'd1);
        #1;
        n_checks++;
        if ({x0_rd_en, y0_rd_en, x1_rd_en, y1_rd_en, out0_wr_en, out1_wr_en, busy, grant} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000000",
                {x0_rd_en, y0_rd_en, x1_rd_en, y1_rd_en, out0_wr_en, out1_wr_en, busy, grant});
        end
        n_checks++;
        if (out0_dout !== 8'h00 || out1_dout !== 8'h00 || count0 !== 16'd0 || count1 !== 16'd0) begin
            n_fail++; $display("FAIL reset_data: dout %h/%h cnt %0d/%0d want 0", out0_dout, out1_dout, count0, count1);
        end
        @(posedge clock); #1;
        clear_logs();
        reset = 1'b0;
        wait_wr(1, ok);
        n_checks++;
        if (!ok || wr_dat[0] !== 8'd2) begin
            n_fail++; $display("FAIL reset_release: ok=%0d data=%h want 02", ok, ok ? wr_dat[0] : 8'hxx);
        end
    endtask

    task automatic test_single_sum();
        bit ok;
        do_reset();
        push0(8'd5, 8'd3);
        wait_wr(1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL sum_timeout: no write got 0 want 1"); end
        else begin
            n_checks++;
            if (rd_req.size() !== 1 || rd_req[0] !== 0) begin
                n_fail++; $display("FAIL sum_pops: got %0d pops want 1 on req0", rd_req.size());
            end
            n_checks++;
            if (wr_req.size() !== 1 || wr_req[0] !== 0 || wr_dat[0] !== 8'd8) begin
                n_fail++; $display("FAIL sum_result: got req%0d %h want req0 08", wr_req[0], wr_dat[0]);
            end
            n_checks++;
            if (wr_cyc[0] - rd_cyc[0] !== 3) begin
                n_fail++; $display("FAIL sum_latency: got %0d want 3", wr_cyc[0] - rd_cyc[0]);
            end
        end
        n_checks++;
        if (count0 !== 16'd1 || count1 !== 16'd0) begin
            n_fail++; $display("FAIL sum_counts: got %0d/%0d want 1/0", count0, count1);
        end
    endtask

    task automatic test_difference();
        bit ok;
        do_reset();
        push1(8'd5, 8'd7);
        wait_rd(1, ok);
        @(negedge clock); #1;
        n_checks++;
        if (!ok || busy !== 1'b1 || grant !== 1'b1) begin
            n_fail++; $display("FAIL diff_grant: ok=%0d busy=%b grant=%b want 1 1 1", ok, busy, grant);
        end
        wait_wr(1, ok);
        n_checks++;
        if (!ok || wr_req.size() !== 1 || wr_req[0] !== 1 || wr_dat[0] !== 8'hFE) begin
            n_fail++; $display("FAIL diff_result: ok=%0d got %h want FE on req1", ok, ok ? wr_dat[0] : 8'hxx);
        end
        n_checks++;
        if (count0 !== 16'd0 || count1 !== 16'd1) begin
            n_fail++; $display("FAIL diff_counts: got %0d/%0d want 0/1", count0, count1);
        end
    endtask

    task automatic test_fairness();
        bit            ok;
        logic [DW-1:0] exp_d [8] = '{8'd3, 8'd9, 8'd7, 8'd18, 8'd11, 8'd27, 8'd15, 8'd36};
        do_reset();
        push0(8'd1, 8'd2);  push1(8'd10, 8'd1);
        push0(8'd3, 8'd4);  push1(8'd20, 8'd2);
        push0(8'd5, 8'd6);  push1(8'd30, 8'd3);
        push0(8'd7, 8'd8);  push1(8'd40, 8'd4);
        wait_wr(8, ok);
        n_checks++;
        if (!ok || wr_req.size() !== 8) begin
            n_fail++; $display("FAIL fair_count: got %0d writes want 8", wr_req.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (wr_req[i] !== i % 2 || wr_dat[i] !== exp_d[i]) begin
                    n_fail++; $display("FAIL fair_order[%0d]: got req%0d %h want req%0d %h",
                        i, wr_req[i], wr_dat[i], i % 2, exp_d[i]);
                end
                if (i > 0) begin
                    n_checks++;
                    if (wr_cyc[i] - wr_cyc[i-1] !== 4) begin
                        n_fail++; $display("FAIL fair_spacing[%0d]: got %0d want 4", i, wr_cyc[i] - wr_cyc[i-1]);
                    end
                end
            end
        end
        n_checks++;
        if (count0 !== 16'd4 || count1 !== 16'd4) begin
            n_fail++; $display("FAIL fair_counts: got %0d/%0d want 4/4", count0, count1);
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        do_reset();
        push0(8'd10, 8'd20);
        push1(8'd9, 8'd4);
        wait_rd(1, ok);
        @(posedge clock); #1;
        out0_full = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        n_checks++;
        if (out0_wr_en !== 1'b0 || busy !== 1'b1 || wr_req.size() !== 0) begin
            n_fail++; $display("FAIL bp_stall: wr_en=%b busy=%b writes=%0d want 0 1 0", out0_wr_en, busy, wr_req.size());
        end
        out0_full = 1'b0;
        wait_wr(2, ok);
        n_checks++;
        if (!ok || wr_req[0] !== 0 || wr_dat[0] !== 8'd30 || wr_cyc[0] - rd_cyc[0] !== 6) begin
            n_fail++; $display("FAIL bp_write: ok=%0d got req%0d %h after %0d want req0 1e after 6",
                ok, wr_req[0], wr_dat[0], wr_cyc[0] - rd_cyc[0]);
        end
        n_checks++;
        if (rd_req.size() !== 2 || rd_req[1] !== 1 || rd_cyc[1] - rd_cyc[0] !== 7) begin
            n_fail++; $display("FAIL bp_other: got %0d pops, second after %0d want 2, 7", rd_req.size(), rd_cyc[1] - rd_cyc[0]);
        end
        n_checks++;
        if (!ok || wr_req[1] !== 1 || wr_dat[1] !== 8'd5) begin
            n_fail++; $display("FAIL bp_req1: got req%0d %h want req1 05", wr_req[1], wr_dat[1]);
        end
    endtask

    task automatic test_overflow();
        bit            ok;
`ifdef ADDSUB_SAT_EN
        logic [DW-1:0] e0 = 8'h7F, e1 = 8'h80;
`else
        logic [DW-1:0] e0 = 8'h80, e1 = 8'h7F;
`endif
        do_reset();
        push0(8'd127, 8'd1);
        push1(8'h80, 8'd1);
        wait_wr(2, ok);
        n_checks++;
        if (!ok || wr_req[0] !== 0 || wr_dat[0] !== e0) begin
            n_fail++; $display("FAIL ovf_sum: got %h want %h", wr_dat[0], e0);
        end
        n_checks++;
        if (!ok || wr_req[1] !== 1 || wr_dat[1] !== e1) begin
            n_fail++; $display("FAIL ovf_diff: got %h want %h", wr_dat[1], e1);
        end
    endtask

    task automatic test_reset_in_exec();
        bit ok;
        do_reset();
        push0(8'd50, 8'd60);
        wait_rd(1, ok);
        @(posedge clock);
        @(posedge clock); #1;
        n_checks++;
        if (!ok || busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_exec_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({x0_rd_en, x1_rd_en, out0_wr_en, out1_wr_en, busy, grant} !== 6'b0 ||
            out0_dout !== 8'h00 || count0 !== 16'd0) begin
            n_fail++; $display("FAIL rst_exec_outputs: ctrl=%b dout=%h cnt=%0d want 0",
                {x0_rd_en, x1_rd_en, out0_wr_en, out1_wr_en, busy, grant}, out0_dout, count0);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        push1(8'd7, 8'd2);
        wait_wr(1, ok);
        n_checks++;
        if (!ok || wr_req.size() !== 1 || wr_req[0] !== 1 || wr_dat[0] !== 8'd5) begin
            n_fail++; $display("FAIL rst_exec_after: got %0d writes, first req%0d %h want 1 req1 05",
                wr_req.size(), ok ? wr_req[0] : -1, ok ? wr_dat[0] : 8'hxx);
        end
        n_checks++;
        if (count0 !== 16'd0 || count1 !== 16'd1) begin
            n_fail++; $display("FAIL rst_exec_counts: got %0d/%0d want 0/1", count0, count1);
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (n_viol !== 0) begin
            n_fail++; $display("FAIL protocol: got %0d violations want 0", n_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_sum();
        test_difference();
        test_fairness();
        test_back_pressure();
        test_overflow();
        test_reset_in_exec();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
